// File: rtl/rq_column_mac.sv
// One column of A' = R*Q for the 4x4 QR iteration: upper-triangular R file, one shared MAC.
// Optional RQ_SATURATE_EN: clamp each rounded element to 16 bits and flag it on out_ovf.
module rq_column_mac #(
   parameter int unsigned FRAC  = 10,
   parameter int unsigned ACC_W = 36
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        r_wr_en,
   input  logic [1:0]  r_wr_row,
   input  logic [1:0]  r_wr_col,
   input  logic [15:0] r_wr_data,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] in_q0,
   input  logic [15:0] in_q1,
   input  logic [15:0] in_q2,
   input  logic [15:0] in_q3,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] out_a0,
   output logic [15:0] out_a1,
   output logic [15:0] out_a2,
   output logic [15:0] out_a3,
   output logic        out_ovf,
   output logic        busy
);

   localparam int unsigned DW        = 16;
   localparam int unsigned PW        = 2 * DW;
   localparam int unsigned N         = 4;
   localparam int unsigned R_ENTRIES = 10;

   localparam logic signed [ACC_W-1:0] RND_HALF = ACC_W'(64'd1 << (FRAC - 1));
`ifdef RQ_SATURATE_EN
   localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(32'sd32767);
   localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-32'sd32768);
`endif

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MAC  = 2'd1,
      S_OUT  = 2'd2
   } state_t;

   state_t state_q, state_d;

   logic [DW-1:0]           r_q [R_ENTRIES];
   logic [DW-1:0]           q_q [N];
   logic [DW-1:0]           res_q [N-1];
   logic [1:0]              row_q, col_q;
   logic signed [ACC_W-1:0] acc_q;
   logic                    ovf_acc_q;

   logic                    accept;
   logic                    row_end;
   logic                    col_last;
   logic signed [DW-1:0]    r_sel, q_sel;
   logic signed [PW-1:0]    prod;
   logic signed [ACC_W-1:0] sum, rnd;
   logic [DW-1:0]           res;
   logic                    clip;

   // Packed index of an upper-triangle element (row-major, diagonal first in each row)
   function automatic logic [3:0] tri_idx(input logic [1:0] row, input logic [1:0] col);
      logic [3:0] base;
      case (row)
         2'd0:    base = 4'd0;
         2'd1:    base = 4'd4;
         2'd2:    base = 4'd7;
         default: base = 4'd9;
      endcase
      return base + 4'(col) - 4'(row);
   endfunction

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // Next state and control strobes
   always_comb begin
      state_d  = state_q;
      accept   = 1'b0;
      row_end  = 1'b0;
      col_last = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (in_valid && in_ready) begin
               accept  = 1'b1;
               state_d = S_MAC;
            end
         end
         S_MAC: begin
            row_end = (col_q == 2'd3);
            if (row_end && (row_q == 2'd3)) begin
               col_last = 1'b1;
               state_d  = S_OUT;
            end
         end
         S_OUT: begin
            if (out_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Handshake/status outputs registered from the next state so they align with it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
         busy      <= 1'b0;
      end else begin
         in_ready  <= (state_d == S_IDLE);
         out_valid <= (state_d == S_OUT);
         busy      <= (state_d != S_IDLE);
      end
   end

   // MAC datapath: lower-triangle reads are zero, product sign-extended into the accumulator
   always_comb begin
      r_sel = (col_q >= row_q) ? r_q[tri_idx(row_q, col_q)] : '0;
      q_sel = q_q[col_q];
      prod  = r_sel * q_sel;
      sum   = acc_q + ACC_W'(prod);
      rnd   = (sum + RND_HALF) >>> FRAC;
`ifdef RQ_SATURATE_EN
      if (rnd > SAT_MAX) begin
         res  = 16'h7FFF;
         clip = 1'b1;
      end else if (rnd < SAT_MIN) begin
         res  = 16'h8000;
         clip = 1'b1;
      end else begin
         res  = DW'(rnd);
         clip = 1'b0;
      end
`else
      res  = DW'(rnd);
      clip = 1'b0;
`endif
   end

   // R register file: writable only in IDLE, upper triangle only
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(R_ENTRIES); i++) r_q[i] <= '0;
      end else if ((state_q == S_IDLE) && r_wr_en && (r_wr_col >= r_wr_row)) begin
         r_q[tri_idx(r_wr_row, r_wr_col)] <= r_wr_data;
      end
   end

   // Column sequencing, accumulation and per-row result capture
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(N); i++)     q_q[i]   <= '0;
         for (int i = 0; i < int'(N) - 1; i++) res_q[i] <= '0;
         row_q     <= '0;
         col_q     <= '0;
         acc_q     <= '0;
         ovf_acc_q <= 1'b0;
      end else if (accept) begin
         q_q[0]    <= in_q0;
         q_q[1]    <= in_q1;
         q_q[2]    <= in_q2;
         q_q[3]    <= in_q3;
         row_q     <= '0;
         col_q     <= '0;
         acc_q     <= '0;
         ovf_acc_q <= 1'b0;
      end else if (state_q == S_MAC) begin
         if (row_end) begin
            case (row_q)
               2'd0:    res_q[0] <= res;
               2'd1:    res_q[1] <= res;
               2'd2:    res_q[2] <= res;
               default: ;
            endcase
            acc_q     <= '0;
            ovf_acc_q <= ovf_acc_q | clip;
            row_q     <= row_q + 2'd1;
            col_q     <= row_q + 2'd1;
         end else begin
            acc_q <= sum;
            col_q <= col_q + 2'd1;
         end
      end
   end

   // Output column: loaded only on the transition into OUT, held otherwise
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_a0  <= '0;
         out_a1  <= '0;
         out_a2  <= '0;
         out_a3  <= '0;
         out_ovf <= 1'b0;
      end else if (col_last) begin
         out_a0  <= res_q[0];
         out_a1  <= res_q[1];
         out_a2  <= res_q[2];
         out_a3  <= res;
         out_ovf <= ovf_acc_q | clip;
      end
   end

endmodule

// File: tb/tb_rq_column_mac.sv
// Directed self-checking bench for rq_column_mac (hand-computed Q6.10 expectations).
module tb_rq_column_mac;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        r_wr_en = 1'b0;
   logic [1:0]  r_wr_row = '0;
   logic [1:0]  r_wr_col = '0;
   logic [15:0] r_wr_data = '0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] in_q0 = '0, in_q1 = '0, in_q2 = '0, in_q3 = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [15:0] out_a0, out_a1, out_a2, out_a3;
   logic        out_ovf;
   logic        busy;

   int tests = 0;
   int fails = 0;

`ifdef RQ_SATURATE_EN
   localparam logic [15:0] EXP_BIG_A0 = 16'h7FFF;
   localparam logic [31:0] EXP_BIG_OVF = 32'd1;
`else
   // 31*31*2 = 1922.0 -> 0x1E0800 in Q6.10; low 16 bits 0x0800
   localparam logic [15:0] EXP_BIG_A0 = 16'h0800;
   localparam logic [31:0] EXP_BIG_OVF = 32'd0;
`endif

   rq_column_mac #(.FRAC(10), .ACC_W(36)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .r_wr_en   (r_wr_en),
      .r_wr_row  (r_wr_row),
      .r_wr_col  (r_wr_col),
      .r_wr_data (r_wr_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_q0     (in_q0),
      .in_q1     (in_q1),
      .in_q2     (in_q2),
      .in_q3     (in_q3),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_a0    (out_a0),
      .out_a1    (out_a1),
      .out_a2    (out_a2),
      .out_a3    (out_a3),
      .out_ovf   (out_ovf),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      tests++;
      assert (observed === expected) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr_r(input logic [1:0] row, input logic [1:0] col, input logic [15:0] data);
      r_wr_en   = 1'b1;
      r_wr_row  = row;
      r_wr_col  = col;
      r_wr_data = data;
      tick();
      r_wr_en   = 1'b0;
   endtask

   task automatic start_col(input logic [15:0] a, input logic [15:0] b,
                            input logic [15:0] c, input logic [15:0] d);
      int n = 0;
      in_q0 = a; in_q1 = b; in_q2 = c; in_q3 = d;
      in_valid = 1'b1;
      while (!in_ready && n < 20) begin
         tick();
         n++;
      end
      tick();
      in_valid = 1'b0;
   endtask

   task automatic wait_out(input string tag);
      int n = 0;
      while (!out_valid && n < 40) begin
         tick();
         n++;
      end
      check(tag, 32'(n), 32'd10);
   endtask

   task automatic check_col(input string tag, input logic [15:0] e0, input logic [15:0] e1,
                            input logic [15:0] e2, input logic [15:0] e3, input logic eovf);
      check({tag, "_a0"}, 32'(out_a0), 32'(e0));
      check({tag, "_a1"}, 32'(out_a1), 32'(e1));
      check({tag, "_a2"}, 32'(out_a2), 32'(e2));
      check({tag, "_a3"}, 32'(out_a3), 32'(e3));
      check({tag, "_ovf"}, 32'(out_ovf), 32'(eovf));
   endtask

   task automatic finish_out();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   initial begin
      // Reset state
      #2;
      check("rst_in_ready", 32'(in_ready), 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check_col("rst", 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0);
      tick();
      rst_n = 1'b1;
      tick();
      check("rel_in_ready", 32'(in_ready), 32'd1);

      // Identity R
      for (int i = 0; i < 4; i++) wr_r(2'(i), 2'(i), 16'h0400);
      start_col(16'h0400, 16'h0200, 16'hFF00, 16'h0800);
      check("id_busy_mac", 32'(busy), 32'd1);
      check("id_in_ready_mac", 32'(in_ready), 32'd0);
      wait_out("id_latency");
      check_col("id", 16'h0400, 16'h0200, 16'hFF00, 16'h0800, 1'b0);
      finish_out();
      check("id_back_idle", 32'(in_ready), 32'd1);

      // Full upper triangle of 1.0
      for (int r = 0; r < 4; r++)
         for (int c = r + 1; c < 4; c++) wr_r(2'(r), 2'(c), 16'h0400);
      start_col(16'h0400, 16'h0400, 16'h0400, 16'h0400);
      wait_out("tri_latency");
      check_col("tri", 16'h1000, 16'h0C00, 16'h0800, 16'h0400, 1'b0);
      finish_out();

      // Lower-triangle write ignored; reset also clears the previous upper entries
      do_reset();
      for (int i = 0; i < 4; i++) wr_r(2'(i), 2'(i), 16'h0400);
      wr_r(2'd2, 2'd1, 16'h0400);
      start_col(16'h0400, 16'h0400, 16'h0400, 16'h0400);
      wait_out("low_latency");
      check_col("low", 16'h0400, 16'h0400, 16'h0400, 16'h0400, 1'b0);
      finish_out();

      // Backpressure: hold OUT for 5 cycles, write R00 inside the window
      start_col(16'h0400, 16'h0C00, 16'hF800, 16'h0001);
      wait_out("bp_latency");
      for (int k = 0; k < 5; k++) begin
         if (k == 2) r_wr_en = 1'b1;
         r_wr_row = 2'd0; r_wr_col = 2'd0; r_wr_data = 16'h7FFF;
         tick();
         r_wr_en = 1'b0;
         check("bp_out_valid", 32'(out_valid), 32'd1);
         check("bp_in_ready", 32'(in_ready), 32'd0);
         check("bp_busy", 32'(busy), 32'd1);
         check("bp_a2_stable", 32'(out_a2), 32'h0000_F800);
      end
      check_col("bp", 16'h0400, 16'h0C00, 16'hF800, 16'h0001, 1'b0);
      finish_out();
      start_col(16'h0400, 16'h0400, 16'h0400, 16'h0400);
      wait_out("bp2_latency");
      check_col("bp2", 16'h0400, 16'h0400, 16'h0400, 16'h0400, 1'b0);
      finish_out();

      // Round-half-up: +0.5 LSB -> 1, -0.5 LSB -> 0, -0.5009 LSB -> -1
      do_reset();
      wr_r(2'd0, 2'd0, 16'h0001);
      wr_r(2'd1, 2'd1, 16'hFFFF);
      wr_r(2'd2, 2'd2, 16'hFFFF);
      start_col(16'h0200, 16'h0200, 16'h0201, 16'h0000);
      wait_out("rnd_latency");
      check_col("rnd", 16'h0001, 16'h0000, 16'hFFFF, 16'h0000, 1'b0);
      finish_out();

      // Overflow: 31*31 + 31*31
      do_reset();
      wr_r(2'd0, 2'd0, 16'h7C00);
      wr_r(2'd0, 2'd1, 16'h7C00);
      start_col(16'h7C00, 16'h7C00, 16'h0000, 16'h0000);
      wait_out("big_latency");
      check("big_a0", 32'(out_a0), 32'(EXP_BIG_A0));
      check("big_a1", 32'(out_a1), 32'd0);
      check("big_ovf", 32'(out_ovf), EXP_BIG_OVF);
      finish_out();

      // Reset at MAC cycle 4 aborts the column and clears R
      start_col(16'h7C00, 16'h7C00, 16'h0400, 16'h0400);
      for (int k = 0; k < 3; k++) tick();
      rst_n = 1'b0;
      #1;
      check("mid_out_valid", 32'(out_valid), 32'd0);
      check("mid_busy", 32'(busy), 32'd0);
      check("mid_in_ready", 32'(in_ready), 32'd0);
      check("mid_out_a0", 32'(out_a0), 32'd0);
      tick();
      rst_n = 1'b1;
      tick();
      check("mid_rel_in_ready", 32'(in_ready), 32'd1);
      start_col(16'h7C00, 16'h7C00, 16'h0400, 16'h0400);
      wait_out("zero_latency");
      check_col("zero", 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0);
      finish_out();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
